aes_uart_sequencer: RTL and testbench

//  Top-level session controller for the UART AES path. Sequences the 16-byte block reader (key, then data),

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_uart_sequencer.sv | 135 +++++++++++++
 tb/tb_aes_uart_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the UART AES session controller.
// Holds the session FSM state encoding and the block geometry used by the
// reader, writer and AES core interfaces.
package aes_pkg;

    localparam int BYTES_PER_BLOCK = 16;
    localparam int BLOCK_W         = BYTES_PER_BLOCK * 8;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_KEY   = 4'd1,
        GAP_KEY  = 4'd2,
        RD_DATA  = 4'd3,
        GAP_DATA = 4'd4,
        RUN      = 4'd5,
        WAIT_AES = 4'd6,
        WRITE    = 4'd7,
        GAP_WR   = 4'd8
    } aes_state_e;

endpackage

// File: rtl/aes_uart_sequencer.sv
// Purpose: one-block session controller: read key (optional) and data, run AES, write result.
// Latency: block load end to AesStart = 2 cycles; AesDone to WrEn = 1 cycle.
// Backpressure: reader/writer hold the FSM via RdAllBytesDone/WrAllBytesDone; AES bounded by AES_TIMEOUT.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   Start, KeyReuse          session request (level) and key-reuse qualifier
//   RdEn/RdBlock/RdAllBytesDone   16-byte reader handshake, byte0 in RdBlock[127:120]
//   AesKey/AesData/AesStart/AesDone/AesResult   AES core interface
//   WrEn/WrResult/WrAllBytesDone  16-byte writer handshake
//   KeyValid, Busy, Error    status (Error is a sticky AES timeout flag)
module aes_uart_sequencer
    import aes_pkg::*;
#(
    parameter int AES_TIMEOUT = 1024,
    parameter int TO_W        = 11
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               KeyReuse,
    output logic               RdEn,
    input  logic [BLOCK_W-1:0] RdBlock,
    input  logic               RdAllBytesDone,
    output logic [BLOCK_W-1:0] AesKey,
    output logic [BLOCK_W-1:0] AesData,
    output logic               AesStart,
    input  logic               AesDone,
    input  logic [BLOCK_W-1:0] AesResult,
    output logic               WrEn,
    output logic [BLOCK_W-1:0] WrResult,
    input  logic               WrAllBytesDone,
    output logic               KeyValid,
    output logic               Busy,
    output logic               Error
);

    // WAIT_AES spans counter values 0..AES_TIMEOUT-1, i.e. AES_TIMEOUT cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(AES_TIMEOUT - 1);

    aes_state_e         state, stateNxt;
    logic [TO_W-1:0]    toCnt, toCntNxt;
    logic [BLOCK_W-1:0] keyNxt, dataNxt, resNxt;
    logic               keyValidNxt, errorNxt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            toCnt    <= '0;
            AesKey   <= '0;
            AesData  <= '0;
            WrResult <= '0;
            KeyValid <= 1'b0;
            Error    <= 1'b0;
        end else begin
            state    <= stateNxt;
            toCnt    <= toCntNxt;
            AesKey   <= keyNxt;
            AesData  <= dataNxt;
            WrResult <= resNxt;
            KeyValid <= keyValidNxt;
            Error    <= errorNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        toCntNxt    = toCnt;
        keyNxt      = AesKey;
        dataNxt     = AesData;
        resNxt      = WrResult;
        keyValidNxt = KeyValid;
        errorNxt    = Error;
        case (state)
            IDLE: begin
                if (Start) begin
                    errorNxt = 1'b0;
                    if (KeyReuse && KeyValid) begin
                        stateNxt = RD_DATA;
                    end else begin
                        keyValidNxt = 1'b0;
                        stateNxt    = RD_KEY;
                    end
                end
            end
            RD_KEY: begin
                if (RdAllBytesDone) begin
                    keyNxt      = RdBlock;
                    keyValidNxt = 1'b1;
                    stateNxt    = GAP_KEY;
                end
            end
            // One cycle with RdEn low lets the reader re-arm its byte count.
            GAP_KEY:  stateNxt = RD_DATA;
            RD_DATA: begin
                if (RdAllBytesDone) begin
                    dataNxt  = RdBlock;
                    stateNxt = GAP_DATA;
                end
            end
            GAP_DATA: stateNxt = RUN;
            RUN: begin
                toCntNxt = '0;
                stateNxt = WAIT_AES;
            end
            WAIT_AES: begin
                // AesDone takes priority over a timeout on the same cycle.
                if (AesDone) begin
                    resNxt   = AesResult;
                    stateNxt = WRITE;
                end else if (toCnt == TO_LAST) begin
                    errorNxt = 1'b1;
                    stateNxt = IDLE;
                end else begin
                    toCntNxt = toCnt + TO_W'(1);
                end
            end
            WRITE: begin
                if (WrAllBytesDone) begin
                    stateNxt = GAP_WR;
                end
            end
            GAP_WR:   stateNxt = IDLE;
            default:  stateNxt = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so RdEn and WrEn are mutually
    // exclusive by construction and drop on the same edge as a reset.
    assign RdEn     = (state == RD_KEY) || (state == RD_DATA);
    assign WrEn     = (state == WRITE);
    assign AesStart = (state == RUN);
    assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_aes_uart_sequencer.sv
module tb_aes_uart_sequencer;
    import aes_pkg::*;

    localparam int AES_TIMEOUT = 1024;
    localparam int TO_W        = 11;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               Start = 1'b0;
    logic               KeyReuse = 1'b0;
    logic               RdEn;
    logic [BLOCK_W-1:0] RdBlock = '0;
    logic               RdAllBytesDone = 1'b0;
    logic [BLOCK_W-1:0] AesKey;
    logic [BLOCK_W-1:0] AesData;
    logic               AesStart;
    logic               AesDone = 1'b0;
    logic [BLOCK_W-1:0] AesResult = '0;
    logic               WrEn;
    logic [BLOCK_W-1:0] WrResult;
    logic               WrAllBytesDone = 1'b0;
    logic               KeyValid;
    logic               Busy;
    logic               Error;

    int checks = 0;
    int failures = 0;

    // Activity monitor
    int   rdRise = 0, wrRise = 0, aesStartCnt = 0, overlapCnt = 0;
    logic rdPrev = 1'b0, wrPrev = 1'b0;

    // Scoreboard: key/data expected at AesStart, result expected at WrEn
    typedef struct packed {
        logic [BLOCK_W-1:0] key;
        logic [BLOCK_W-1:0] data;
    } in_exp_t;
    in_exp_t            expIn[$];
    logic [BLOCK_W-1:0] expOut[$];
    logic [BLOCK_W-1:0] modelKey = '0;

    aes_uart_sequencer #(.AES_TIMEOUT(AES_TIMEOUT), .TO_W(TO_W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .KeyReuse(KeyReuse),
        .RdEn(RdEn), .RdBlock(RdBlock), .RdAllBytesDone(RdAllBytesDone),
        .AesKey(AesKey), .AesData(AesData), .AesStart(AesStart),
        .AesDone(AesDone), .AesResult(AesResult),
        .WrEn(WrEn), .WrResult(WrResult), .WrAllBytesDone(WrAllBytesDone),
        .KeyValid(KeyValid), .Busy(Busy), .Error(Error)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (RdEn === 1'b1 && rdPrev !== 1'b1) rdRise++;
        if (WrEn === 1'b1 && wrPrev !== 1'b1) wrRise++;
        if (RdEn === 1'b1 && WrEn === 1'b1) overlapCnt++;
        if (AesStart === 1'b1) aesStartCnt++;
        rdPrev = RdEn;
        wrPrev = WrEn;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkB(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkI(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [BLOCK_W-1:0] junk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One full session. loadKey is the bench's own expectation of whether a key
    // read happens (KeyReuse with a valid key skips it).
    task automatic session(input string nm, input logic kr, input logic loadKey,
                           input logic [BLOCK_W-1:0] key, input logic [BLOCK_W-1:0] data,
                           input logic [BLOCK_W-1:0] res, input int aesDelay,
                           input logic holdStart, input logic spur, input logic rstInWrite);
        int rd0, st0, wr0;
        in_exp_t e;
        logic [BLOCK_W-1:0] r;
        rd0 = rdRise; st0 = aesStartCnt; wr0 = wrRise;
        if (loadKey) modelKey = key;
        expIn.push_back('{key: modelKey, data: data});
        expOut.push_back(res);

        Start = 1'b1; KeyReuse = kr;
        step();
        if (!holdStart) Start = 1'b0;
        chk1({nm, "_busy"}, Busy, 1'b1);
        chk1({nm, "_rden"}, RdEn, 1'b1);
        chk1({nm, "_err_clr"}, Error, 1'b0);

        if (loadKey) begin
            chk1({nm, "_kv_cleared"}, KeyValid, 1'b0);
            AesDone = spur; WrAllBytesDone = spur; AesResult = junk();
            step();
            AesDone = 1'b0; WrAllBytesDone = 1'b0;
            chk1({nm, "_rdkey_hold"}, RdEn, 1'b1);
            chk1({nm, "_rdkey_nowr"}, WrEn, 1'b0);
            chk1({nm, "_rdkey_nostart"}, AesStart, 1'b0);
            step();
            RdBlock = key; RdAllBytesDone = 1'b1;
            step();
            RdAllBytesDone = 1'b0; RdBlock = junk();
            chk1({nm, "_gapkey_rden"}, RdEn, 1'b0);
            chk1({nm, "_keyvalid"}, KeyValid, 1'b1);
            chkB({nm, "_aeskey"}, AesKey, modelKey);
            step();
            chk1({nm, "_rddata_rden"}, RdEn, 1'b1);
        end

        step();
        RdBlock = data; RdAllBytesDone = 1'b1;
        step();
        RdAllBytesDone = 1'b0; RdBlock = junk();
        chk1({nm, "_gapdata_rden"}, RdEn, 1'b0);
        chk1({nm, "_gapdata_nostart"}, AesStart, 1'b0);
        step();
        chk1({nm, "_aesstart"}, AesStart, 1'b1);
        e = expIn.pop_front();
        chkB({nm, "_key_at_start"}, AesKey, e.key);
        chkB({nm, "_data_at_start"}, AesData, e.data);
        step();
        chk1({nm, "_aesstart_drop"}, AesStart, 1'b0);
        repeat (aesDelay - 1) step();
        AesDone = 1'b1; AesResult = res;
        step();
        AesDone = 1'b0; AesResult = junk();
        chk1({nm, "_wren"}, WrEn, 1'b1);
        r = expOut.pop_front();
        chkB({nm, "_wrresult"}, WrResult, r);

        if (rstInWrite) begin
            Rst = 1'b1;
            step();
            Rst = 1'b0;
            modelKey = '0;
            chk1({nm, "_rst_wren"}, WrEn, 1'b0);
            chk1({nm, "_rst_kv"}, KeyValid, 1'b0);
            chk1({nm, "_rst_busy"}, Busy, 1'b0);
            chkB({nm, "_rst_key"}, AesKey, '0);
            return;
        end

        repeat (4) step();
        chk1({nm, "_wren_hold"}, WrEn, 1'b1);
        chkB({nm, "_wrresult_frozen"}, WrResult, r);
        WrAllBytesDone = 1'b1;
        step();
        WrAllBytesDone = 1'b0;
        chk1({nm, "_gapwr_wren"}, WrEn, 1'b0);
        chk1({nm, "_gapwr_busy"}, Busy, 1'b1);
        step();
        chk1({nm, "_idle_busy"}, Busy, 1'b0);
        chk1({nm, "_idle_kv"}, KeyValid, 1'b1);
        chkI({nm, "_rd_bursts"}, rdRise - rd0, loadKey ? 2 : 1);
        chkI({nm, "_start_pulses"}, aesStartCnt - st0, 1);
        chkI({nm, "_wr_bursts"}, wrRise - wr0, 1);
    endtask

    initial begin
        int wr0;
        in_exp_t e;
        logic [BLOCK_W-1:0] dataT;

        repeat (3) step();
        Rst = 1'b0;
        chk1("rst_rden", RdEn, 1'b0);
        chk1("rst_wren", WrEn, 1'b0);
        chk1("rst_aesstart", AesStart, 1'b0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_error", Error, 1'b0);
        chk1("rst_keyvalid", KeyValid, 1'b0);
        chkB("rst_aeskey", AesKey, '0);
        chkB("rst_aesdata", AesData, '0);
        chkB("rst_wrresult", WrResult, '0);

        // Spurious completions while idle
        AesDone = 1'b1; WrAllBytesDone = 1'b1; RdAllBytesDone = 1'b1;
        step();
        AesDone = 1'b0; WrAllBytesDone = 1'b0; RdAllBytesDone = 1'b0;
        step();
        chk1("idle_spur_busy", Busy, 1'b0);
        chk1("idle_spur_kv", KeyValid, 1'b0);

        session("s1", 1'b0, 1'b1, 128'h000102030405060708090A0B0C0D0E0F,
                128'h00112233445566778899AABBCCDDEEFF,
                128'h69C4E0D86A7B0430D8CDB78070B4C55A, 10, 1'b0, 1'b1, 1'b0);
        session("s2", 1'b1, 1'b0, '0, 128'hDEADBEEF_00000000_CAFEF00D_12345678,
                128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 3, 1'b0, 1'b0, 1'b0);

        // AES timeout with reused key
        wr0 = wrRise;
        dataT = 128'hA5A5A5A5_5A5A5A5A_0000FFFF_FFFF0000;
        expIn.push_back('{key: modelKey, data: dataT});
        Start = 1'b1; KeyReuse = 1'b1;
        step();
        Start = 1'b0;
        chk1("to_rden", RdEn, 1'b1);
        RdBlock = dataT; RdAllBytesDone = 1'b1;
        step();
        RdAllBytesDone = 1'b0;
        step();
        chk1("to_aesstart", AesStart, 1'b1);
        e = expIn.pop_front();
        chkB("to_key", AesKey, e.key);
        chkB("to_data", AesData, e.data);
        repeat (AES_TIMEOUT) step();
        chk1("to_err_before", Error, 1'b0);
        chk1("to_busy_before", Busy, 1'b1);
        step();
        chk1("to_err", Error, 1'b1);
        chk1("to_busy", Busy, 1'b0);
        chk1("to_wren", WrEn, 1'b0);
        AesDone = 1'b1; AesResult = junk();
        step();
        AesDone = 1'b0;
        step();
        chk1("to_err_sticky", Error, 1'b1);
        chk1("to_late_done_busy", Busy, 1'b0);
        chkI("to_no_write", wrRise - wr0, 0);

        // Reset during WRITE, then a clean session needing a fresh key
        session("s3", 1'b0, 1'b1, 128'h11111111_22222222_33333333_44444444,
                128'h55555555_66666666_77777777_88888888,
                128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 5, 1'b0, 1'b0, 1'b1);
        step();
        session("s4", 1'b1, 1'b1, 128'hFEDCBA98_76543210_01234567_89ABCDEF,
                128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97, 4, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back sessions with a single idle cycle
        session("b1", 1'b0, 1'b1, 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF,
                128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF,
                128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF, 2, 1'b1, 1'b0, 1'b0);
        session("b2", 1'b1, 1'b0, '0, 128'h10203040_50607080_90A0B0C0_D0E0F000,
                128'h0A0B0C0D_0E0F1011_12131415_16171819, 6, 1'b1, 1'b0, 1'b0);
        session("b3", 1'b0, 1'b1, 128'h00000000_00000000_00000000_00000001,
                128'h80000000_00000000_00000000_00000000,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1, 1'b0, 1'b0, 1'b0);

        step();
        chk1("end_busy", Busy, 1'b0);
        chkI("rd_wr_exclusive", overlapCnt, 0);
        chkI("scoreboard_empty", expIn.size() + expOut.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
